des_entry_sequencer: RTL

Top-level sequencer for the text-encryption design. It walks the user through entering a 64-bit key and a 64-bit plaintext as four 16-bit switch words each, one button press per word. It then launches the DES core with a start/done handshake and holds the ciphertext. Its 5-bit phase output uses the same state codes the LCD message driver decodes, so the LCD follows the sequencer directly.

---
 rtl/des_entry_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/des_entry_sequencer.sv
// Entry sequencer for the text-encryption design: collects a key and a plaintext as
// four 16-bit switch words each, launches the DES core and holds the ciphertext.
`timescale 1ns/1ps

module des_entry_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_n,
    input  logic [15:0] sw,
    input  logic        des_done,
    input  logic [63:0] des_result,
    output logic        des_start,
    output logic [63:0] des_key,
    output logic [63:0] des_data,
    output logic [63:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [4:0]  phase
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    // Codes are shared with the LCD message driver; do not renumber.
    typedef enum logic [4:0] {
        START      = 5'd0,
        IN_KEY_1   = 5'd1,  WAITING_1 = 5'd2,
        IN_KEY_2   = 5'd3,  WAITING_2 = 5'd4,
        IN_KEY_3   = 5'd5,  WAITING_3 = 5'd6,
        IN_KEY_4   = 5'd7,  WAITING_4 = 5'd8,
        DISP_KEY   = 5'd9,
        IN_VALUE_1 = 5'd10, WAITING_5 = 5'd11,
        IN_VALUE_2 = 5'd12, WAITING_6 = 5'd13,
        IN_VALUE_3 = 5'd14, WAITING_7 = 5'd15,
        IN_VALUE_4 = 5'd16, WAITING_8 = 5'd17,
        DISP_VALUE = 5'd18,
        WAITING    = 5'd19,
        ENCR       = 5'd20,
        DONE       = 5'd21,
        ERROR      = 5'd31
    } state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          sync_meta;
    logic          sync_lvl;
    logic          sync_prev;
    logic          press;
    logic          released;

    // Synchronizer and edge registers reset to the released level so reset never
    // manufactures a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b1;
            sync_lvl  <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each stage see the previous stage's
            // old value, which is what forms the shift chain.
            sync_meta <= btn_n;
            sync_lvl  <= sync_meta;
            sync_prev <= sync_lvl;
        end
    end

    assign press    = sync_prev & ~sync_lvl;
    assign released = sync_lvl;
    assign phase    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= START;
            tmo_cnt      <= '0;
            des_start    <= 1'b0;
            des_key      <= '0;
            des_data     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            des_start <= 1'b0;
            case (state)
                START:      if (press) state <= IN_KEY_1;
                IN_KEY_1:   if (press) begin des_key[63:48] <= sw; state <= WAITING_1; end
                WAITING_1:  if (released) state <= IN_KEY_2;
                IN_KEY_2:   if (press) begin des_key[47:32] <= sw; state <= WAITING_2; end
                WAITING_2:  if (released) state <= IN_KEY_3;
                IN_KEY_3:   if (press) begin des_key[31:16] <= sw; state <= WAITING_3; end
                WAITING_3:  if (released) state <= IN_KEY_4;
                IN_KEY_4:   if (press) begin des_key[15:0] <= sw; state <= WAITING_4; end
                WAITING_4:  if (released) state <= DISP_KEY;
                DISP_KEY:   if (press) state <= IN_VALUE_1;
                IN_VALUE_1: if (press) begin des_data[63:48] <= sw; state <= WAITING_5; end
                WAITING_5:  if (released) state <= IN_VALUE_2;
                IN_VALUE_2: if (press) begin des_data[47:32] <= sw; state <= WAITING_6; end
                WAITING_6:  if (released) state <= IN_VALUE_3;
                IN_VALUE_3: if (press) begin des_data[31:16] <= sw; state <= WAITING_7; end
                WAITING_7:  if (released) state <= IN_VALUE_4;
                IN_VALUE_4: if (press) begin des_data[15:0] <= sw; state <= WAITING_8; end
                WAITING_8:  if (released) state <= DISP_VALUE;
                DISP_VALUE: state <= WAITING;
                WAITING: begin
                    if (press) begin
                        state     <= ENCR;
                        des_start <= 1'b1;
                        busy      <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                ENCR: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // A done arriving in the expiry cycle still counts as success.
                    if (des_done) begin
                        result       <= des_result;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (tmo_cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= ERROR;
                    end
                end
                DONE, ERROR: ;
                default: begin
                    busy  <= 1'b0;
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule
